// File: rtl/ising_config_pkg.sv
// ising_config: host register map for the Ising-machine fabric, plus the
// command-controller types and decode helper built on top of it.
package ising_config;

  // Trigger registers
  localparam logic [15:0] REG_RUN_TRIG  = 16'h0000;
  localparam logic [15:0] REG_DEL_TRIG  = 16'h0001;
  localparam logic [15:0] REG_HALT      = 16'h0002;
  localparam logic [15:0] REG_ADC_RUN   = 16'h0005;

  // Plain config registers
  localparam logic [15:0] REG_CFG_03 = 16'h0003;
  localparam logic [15:0] REG_CFG_04 = 16'h0004;
  localparam logic [15:0] REG_CFG_0E = 16'h000E;
  localparam logic [15:0] REG_CFG_11 = 16'h0011;
  localparam logic [15:0] REG_CFG_17 = 16'h0017;
  localparam logic [15:0] REG_CFG_18 = 16'h0018;
  localparam logic [15:0] REG_CFG_19 = 16'h0019;
  localparam logic [15:0] REG_CFG_1C = 16'h001C;
  localparam logic [15:0] REG_CFG_1D = 16'h001D;
  localparam logic [15:0] REG_CFG_1E = 16'h001E;
  localparam logic [15:0] REG_CFG_21 = 16'h0021;
  localparam logic [15:0] REG_CFG_22 = 16'h0022;
  localparam logic [15:0] REG_CFG_23 = 16'h0023;
  localparam logic [15:0] REG_CFG_26 = 16'h0026;
  localparam logic [15:0] REG_CFG_29 = 16'h0029;
  localparam logic [15:0] REG_CFG_2A = 16'h002A;
  localparam logic [15:0] REG_CFG_2B = 16'h002B;

  // Indirect table pointer/data register pairs
  localparam logic [15:0] REG_MAC_ADDR  = 16'h000C;
  localparam logic [15:0] REG_MAC_DATA  = 16'h000D;
  localparam logic [15:0] REG_NL_ADDR   = 16'h000F;
  localparam logic [15:0] REG_NL_DATA   = 16'h0010;
  localparam logic [15:0] REG_AOUT_ADDR = 16'h0015;
  localparam logic [15:0] REG_AOUT_DATA = 16'h0016;
  localparam logic [15:0] REG_BOUT_ADDR = 16'h001A;
  localparam logic [15:0] REG_BOUT_DATA = 16'h001B;
  localparam logic [15:0] REG_COUT_ADDR = 16'h001F;
  localparam logic [15:0] REG_COUT_DATA = 16'h0020;
  localparam logic [15:0] REG_ANL_ADDR  = 16'h0027;
  localparam logic [15:0] REG_ANL_DATA  = 16'h0028;

  // FIFO push registers
  localparam logic [15:0] REG_A_FIFO = 16'h0024;
  localparam logic [15:0] REG_C_FIFO = 16'h0025;

  // Readback registers
  localparam logic [15:0] REG_RB_06 = 16'h0006;
  localparam logic [15:0] REG_RB_07 = 16'h0007;
  localparam logic [15:0] REG_RB_08 = 16'h0008;
  localparam logic [15:0] REG_RB_09 = 16'h0009;
  localparam logic [15:0] REG_RB_0A = 16'h000A;
  localparam logic [15:0] REG_RB_0B = 16'h000B;
  localparam logic [15:0] REG_RB_12 = 16'h0012;
  localparam logic [15:0] REG_RB_13 = 16'h0013;
  localparam logic [15:0] REG_RB_14 = 16'h0014;

  // Controller extensions
  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_RB_WAIT, ST_RB_CAP} cmd_state_e;

  typedef enum logic [3:0] {
    ACT_NONE, ACT_RUN, ACT_DEL, ACT_HALT, ACT_ADC, ACT_CFG,
    ACT_TPTR, ACT_TDAT, ACT_FIFO_A, ACT_FIFO_C, ACT_RB
  } cmd_act_e;

  typedef struct packed {
    cmd_act_e   act;
    logic [2:0] sel;
  } cmd_dec_t;

  localparam logic [2:0] TBL_SEL_MAC  = 3'd0;
  localparam logic [2:0] TBL_SEL_NL   = 3'd1;
  localparam logic [2:0] TBL_SEL_AOUT = 3'd2;
  localparam logic [2:0] TBL_SEL_BOUT = 3'd3;
  localparam logic [2:0] TBL_SEL_COUT = 3'd4;
  localparam logic [2:0] TBL_SEL_ANL  = 3'd5;

  localparam int NUM_TBL = 6;
  localparam int NUM_CFG = 17;
  localparam int NUM_RB  = 9;

  localparam logic [2:0]  TBL_SEL_LIST [NUM_TBL] = '{TBL_SEL_MAC, TBL_SEL_NL, TBL_SEL_AOUT,
                                                     TBL_SEL_BOUT, TBL_SEL_COUT, TBL_SEL_ANL};
  localparam logic [15:0] TBL_PTR_REGS [NUM_TBL] = '{REG_MAC_ADDR, REG_NL_ADDR, REG_AOUT_ADDR,
                                                     REG_BOUT_ADDR, REG_COUT_ADDR, REG_ANL_ADDR};
  localparam logic [15:0] TBL_DAT_REGS [NUM_TBL] = '{REG_MAC_DATA, REG_NL_DATA, REG_AOUT_DATA,
                                                     REG_BOUT_DATA, REG_COUT_DATA, REG_ANL_DATA};
  localparam logic [15:0] CFG_REGS [NUM_CFG] = '{
    REG_CFG_03, REG_CFG_04, REG_CFG_0E, REG_CFG_11, REG_CFG_17, REG_CFG_18,
    REG_CFG_19, REG_CFG_1C, REG_CFG_1D, REG_CFG_1E, REG_CFG_21, REG_CFG_22,
    REG_CFG_23, REG_CFG_26, REG_CFG_29, REG_CFG_2A, REG_CFG_2B};
  localparam logic [15:0] RB_REGS [NUM_RB] = '{
    REG_RB_06, REG_RB_07, REG_RB_08, REG_RB_09, REG_RB_0A, REG_RB_0B,
    REG_RB_12, REG_RB_13, REG_RB_14};

  // Map a host address to its action; register sets are disjoint so the
  // loops never compete for the same address.
  function automatic cmd_dec_t decode_addr(input logic [15:0] a);
    cmd_dec_t d;
    d.act = ACT_NONE;
    d.sel = '0;
    if (a == REG_RUN_TRIG)      d.act = ACT_RUN;
    else if (a == REG_DEL_TRIG) d.act = ACT_DEL;
    else if (a == REG_HALT)     d.act = ACT_HALT;
    else if (a == REG_ADC_RUN)  d.act = ACT_ADC;
    else if (a == REG_A_FIFO)   d.act = ACT_FIFO_A;
    else if (a == REG_C_FIFO)   d.act = ACT_FIFO_C;
    for (int i = 0; i < NUM_CFG; i++)
      if (a == CFG_REGS[i]) d.act = ACT_CFG;
    for (int i = 0; i < NUM_RB; i++)
      if (a == RB_REGS[i]) d.act = ACT_RB;
    for (int i = 0; i < NUM_TBL; i++) begin
      if (a == TBL_PTR_REGS[i]) begin d.act = ACT_TPTR; d.sel = TBL_SEL_LIST[i]; end
      if (a == TBL_DAT_REGS[i]) begin d.act = ACT_TDAT; d.sel = TBL_SEL_LIST[i]; end
    end
    return d;
  endfunction

endpackage

// File: rtl/gpio_cmd_ctrl_sync.sv
// gpio_sync_edge: multi-flop synchronizer for the host GPIO word plus
// w_clk rising-edge detect. addr/data are taken from the same synced word.
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] gpio_in,
  output logic        wr_stb,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);

  logic [SYNC_STAGES-1:0][24:0] sync_q;
  logic                         prev_w_q;

  // Shift the host word through the synchronizer, remember last w_clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      prev_w_q <= 1'b0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_w_q <= sync_q[SYNC_STAGES-1][24];
    end
  end

  assign wr_stb  = sync_q[SYNC_STAGES-1][24] & ~prev_w_q;
  assign wr_addr = sync_q[SYNC_STAGES-1][15:0];
  assign wr_data = sync_q[SYNC_STAGES-1][23:16];

endmodule

// File: rtl/gpio_cmd_ctrl.sv
// gpio_cmd_ctrl: decodes synchronized host writes into trigger pulses,
// config writes, auto-incrementing table writes, FIFO pushes and readbacks.
// RB_LAT is expected to be >= 1.
module gpio_cmd_ctrl
  import ising_config::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RB_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] gpio_in,
  output logic        run_trig,
  output logic        del_trig,
  output logic        halt,
  output logic        adc_run,
  output logic        cfg_we,
  output logic [15:0] cfg_addr,
  output logic [7:0]  cfg_data,
  output logic        tbl_we,
  output logic [2:0]  tbl_sel,
  output logic [7:0]  tbl_addr,
  output logic [7:0]  tbl_data,
  output logic        a_wr_en,
  output logic        c_wr_en,
  output logic [7:0]  fifo_data,
  input  logic        a_full,
  input  logic        c_full,
  output logic [15:0] rb_addr,
  input  logic [7:0]  rb_data,
  output logic [7:0]  gpio_rd_data,
  output logic        gpio_rd_ack,
  output logic [2:0]  err_flags
);

  logic        wr_stb;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .gpio_in (gpio_in),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  cmd_state_e  state_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic [7:0]  cnt_q;
  logic [7:0]  ptr_q [NUM_TBL];
  cmd_dec_t    dec;

  // Decode the captured address; used only in DECODE
  always_comb dec = decode_addr(addr_q);

  // Command FSM; every output is a register written here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < NUM_TBL; i++) ptr_q[i] <= '0;
      run_trig     <= 1'b0;
      del_trig     <= 1'b0;
      halt         <= 1'b0;
      adc_run      <= 1'b0;
      cfg_we       <= 1'b0;
      cfg_addr     <= '0;
      cfg_data     <= '0;
      tbl_we       <= 1'b0;
      tbl_sel      <= '0;
      tbl_addr     <= '0;
      tbl_data     <= '0;
      a_wr_en      <= 1'b0;
      c_wr_en      <= 1'b0;
      fifo_data    <= '0;
      rb_addr      <= '0;
      gpio_rd_data <= '0;
      gpio_rd_ack  <= 1'b0;
      err_flags    <= '0;
    end else begin
      run_trig <= 1'b0;
      del_trig <= 1'b0;
      halt     <= 1'b0;
      adc_run  <= 1'b0;
      cfg_we   <= 1'b0;
      tbl_we   <= 1'b0;
      a_wr_en  <= 1'b0;
      c_wr_en  <= 1'b0;
      // Strobes arriving while a command is in flight are dropped
      if (wr_stb && state_q != ST_IDLE) err_flags[1] <= 1'b1;
      case (state_q)
        ST_IDLE: if (wr_stb) begin
          addr_q  <= wr_addr;
          data_q  <= wr_data;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          state_q <= ST_IDLE;
          case (dec.act)
            ACT_RUN:  run_trig <= 1'b1;
            ACT_DEL:  del_trig <= 1'b1;
            ACT_HALT: halt     <= 1'b1;
            ACT_ADC:  adc_run  <= 1'b1;
            ACT_CFG: begin
              cfg_we   <= 1'b1;
              cfg_addr <= addr_q;
              cfg_data <= data_q;
            end
            ACT_TPTR: ptr_q[dec.sel] <= data_q;
            ACT_TDAT: begin
              tbl_we         <= 1'b1;
              tbl_sel        <= dec.sel;
              tbl_addr       <= ptr_q[dec.sel];
              tbl_data       <= data_q;
              ptr_q[dec.sel] <= ptr_q[dec.sel] + 8'd1;
            end
            ACT_FIFO_A: if (a_full) err_flags[0] <= 1'b1;
                        else begin a_wr_en <= 1'b1; fifo_data <= data_q; end
            ACT_FIFO_C: if (c_full) err_flags[0] <= 1'b1;
                        else begin c_wr_en <= 1'b1; fifo_data <= data_q; end
            ACT_RB: begin
              rb_addr <= addr_q;
              cnt_q   <= '0;
              state_q <= ST_RB_WAIT;
            end
            default: err_flags[2] <= 1'b1;
          endcase
        end
        ST_RB_WAIT: begin
          if (cnt_q == 8'(RB_LAT - 1)) state_q <= ST_RB_CAP;
          else                         cnt_q   <= cnt_q + 8'd1;
        end
        ST_RB_CAP: begin
          gpio_rd_data <= rb_data;
          gpio_rd_ack  <= ~gpio_rd_ack;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
